// File: rtl/conv_layer_scheduler_if.sv
// conv_layer_scheduler_if: command, store-done, datapath handshake and memory/MAC control bundle.
interface conv_layer_scheduler_if;
    logic        layer1_input_store_done;
    logic        layer1_weight_store_done;
    logic        layer1_bias_store_done;
    logic [1:0]  image_set_register_data_output;
    logic        dp_stall;
    logic        dp_done;
    logic        pixel_rd_en;
    logic [15:0] pixel_rd_addr;
    logic        pad_zero;
    logic [4:0]  weight_tap_idx;
    logic        mac_valid;
    logic        mac_first;
    logic        mac_last;
    logic [15:0] result_addr;
    logic        busy;
    logic        interrupt_register_write_signal;
    logic        interrupt_register_data_in;

    modport master (
        input  layer1_input_store_done, layer1_weight_store_done, layer1_bias_store_done,
        input  image_set_register_data_output, dp_stall, dp_done,
        output pixel_rd_en, pixel_rd_addr, pad_zero, weight_tap_idx,
        output mac_valid, mac_first, mac_last, result_addr, busy,
        output interrupt_register_write_signal, interrupt_register_data_in
    );

    modport slave (
        output layer1_input_store_done, layer1_weight_store_done, layer1_bias_store_done,
        output image_set_register_data_output, dp_stall, dp_done,
        input  pixel_rd_en, pixel_rd_addr, pad_zero, weight_tap_idx,
        input  mac_valid, mac_first, mac_last, result_addr, busy,
        input  interrupt_register_write_signal, interrupt_register_data_in
    );
endinterface

// File: rtl/conv_layer_scheduler.sv
// conv_layer_scheduler: walks every output pixel of a 3x3 conv layer, issuing one tap per cycle
// (channel, ky, kx order) with zero padding at the image border, then waits for the datapath.
module conv_layer_scheduler #(
    parameter int IMG_W = 32,
    parameter int IN_CH = 3,
    parameter int TAPS  = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    conv_layer_scheduler_if.master io
);
    localparam int CW  = $clog2(IMG_W);
    localparam int ICW = (IN_CH > 1) ? $clog2(IN_CH) : 1;
    localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, WAIT_RES = 2'd2, DONE = 2'd3;
    localparam logic [4:0]     LAST_TAP = 5'(IN_CH * TAPS - 1);
    localparam logic [CW-1:0]  LAST_RC  = CW'(IMG_W - 1);
    localparam logic [ICW-1:0] LAST_IC  = ICW'(IN_CH - 1);
    localparam logic [CW+1:0]  W_L      = (CW + 2)'(IMG_W);
    localparam logic [15:0]    W_16     = 16'(IMG_W);
    localparam logic [15:0]    WW_16    = 16'(IMG_W * IMG_W);

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  r_q, r_d, c_q, c_d;
    logic [4:0]     tap_q, tap_d;
    logic [ICW-1:0] ic_q, ic_d;
    logic [1:0]     ky_q, ky_d, kx_q, kx_d;
    logic           in_rdy_q, in_rdy_d, w_rdy_q, w_rdy_d, b_rdy_q, b_rdy_d;
    logic           start, abort, issue, in_img, last_px;
    logic [CW+1:0]  row_s, col_s;

    assign start   = io.image_set_register_data_output == 2'b01;
    assign abort   = io.image_set_register_data_output == 2'b10 && state_q != IDLE;
    assign issue   = state_q == FETCH && !io.dp_stall;
    assign last_px = r_q == LAST_RC && c_q == LAST_RC;
    // Offsets wrap unsigned, so a -1 position becomes large and fails the bound test.
    assign row_s  = {2'b00, r_q} + {{CW{1'b0}}, ky_q} - {{(CW + 1){1'b0}}, 1'b1};
    assign col_s  = {2'b00, c_q} + {{CW{1'b0}}, kx_q} - {{(CW + 1){1'b0}}, 1'b1};
    assign in_img = row_s < W_L && col_s < W_L;

    assign io.busy           = state_q != IDLE;
    assign io.mac_valid      = issue;
    assign io.mac_first      = issue && tap_q == 5'd0;
    assign io.mac_last       = issue && tap_q == LAST_TAP;
    assign io.pad_zero       = issue && !in_img;
    assign io.pixel_rd_en    = issue && in_img;
    assign io.pixel_rd_addr  = io.pixel_rd_en ? 16'(ic_q) * WW_16 + 16'(row_s) * W_16 + 16'(col_s) : 16'd0;
    assign io.weight_tap_idx = state_q == FETCH ? tap_q : 5'd0;
    assign io.result_addr    = (state_q == FETCH || state_q == WAIT_RES) ? 16'(r_q) * W_16 + 16'(c_q) : 16'd0;
    assign io.interrupt_register_write_signal = state_q == DONE && !abort;
    assign io.interrupt_register_data_in      = io.interrupt_register_write_signal;

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        c_d      = c_q;
        tap_d    = tap_q;
        ic_d     = ic_q;
        ky_d     = ky_q;
        kx_d     = kx_q;
        in_rdy_d = in_rdy_q | io.layer1_input_store_done;
        w_rdy_d  = w_rdy_q | io.layer1_weight_store_done;
        b_rdy_d  = b_rdy_q | io.layer1_bias_store_done;
        if (state_q == IDLE) begin
            if (start && in_rdy_d && w_rdy_d && b_rdy_d) begin
                state_d = FETCH;
                {r_d, c_d, tap_d, ic_d, ky_d, kx_d} = '0;
            end
        end else if (abort) begin
            state_d  = IDLE;
            {r_d, c_d, tap_d, ic_d, ky_d, kx_d} = '0;
            in_rdy_d = 1'b0;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end else if (issue) begin
            state_d = tap_q == LAST_TAP ? WAIT_RES : FETCH;
            tap_d   = tap_q == LAST_TAP ? 5'd0 : tap_q + 5'd1;
            kx_d    = kx_q == 2'd2 ? 2'd0 : kx_q + 2'd1;
            ky_d    = kx_q != 2'd2 ? ky_q : ky_q == 2'd2 ? 2'd0 : ky_q + 2'd1;
            ic_d    = (kx_q != 2'd2 || ky_q != 2'd2) ? ic_q : ic_q == LAST_IC ? '0 : ic_q + ICW'(1);
        end else if (state_q == WAIT_RES && io.dp_done) begin
            state_d  = last_px ? DONE : FETCH;
            c_d      = c_q == LAST_RC ? '0 : c_q + CW'(1);
            r_d      = c_q != LAST_RC ? r_q : r_q == LAST_RC ? '0 : r_q + CW'(1);
            in_rdy_d = last_px ? 1'b0 : in_rdy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            r_q      <= '0;
            c_q      <= '0;
            tap_q    <= '0;
            ic_q     <= '0;
            ky_q     <= '0;
            kx_q     <= '0;
            in_rdy_q <= 1'b0;
            w_rdy_q  <= 1'b0;
            b_rdy_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            c_q      <= c_d;
            tap_q    <= tap_d;
            ic_q     <= ic_d;
            ky_q     <= ky_d;
            kx_q     <= kx_d;
            in_rdy_q <= in_rdy_d;
            w_rdy_q  <= w_rdy_d;
            b_rdy_q  <= b_rdy_d;
        end
    end
endmodule
